stall_control_block: RTL and testbench



---
 rtl/ntp_isa_pkg.sv | 15 +
 rtl/stall_control_block_if.sv | 22 ++
 rtl/stall_oneshot_counter.sv | 33 +++
 rtl/stall_control_block.sv | 64 ++++++
 tb/tb_stall_control_block.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ntp_isa_pkg.sv
// ntp_isa_pkg: shared ISA constants for the 24-bit NTP pipeline.
//   OPC_MSB/OPC_LSB : opcode field position within a 24-bit instruction
//   OPC_W           : opcode field width
//   OPC_HLT/LD/JMP  : opcodes decoded by the stall logic
package ntp_isa_pkg;

    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 19;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_HLT = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_LD  = 5'b10100;
    localparam logic [OPC_W-1:0] OPC_JMP = 5'b11110;

endpackage

// File: rtl/stall_control_block_if.sv
// stall_control_block_if: instruction in, stall requests out.
//   ins         : current instruction word (driven by master)
//   Stall       : combinational stall request (driven by slave)
//   Stall_pm    : Stall delayed one clk (driven by slave)
//   stall_count : stalled-cycle counter, only when STALL_STATS_EN is defined
// Modports: master = fetch/decode side, slave = stall_control_block.
interface stall_control_block_if #(
    parameter int INS_W = 24
);
    logic [INS_W-1:0] ins;
    logic             Stall;
    logic             Stall_pm;
`ifdef STALL_STATS_EN
    logic [15:0]      stall_count;

    modport master (output ins, input Stall, input Stall_pm, input stall_count);
    modport slave  (input ins, output Stall, output Stall_pm, output stall_count);
`else
    modport master (output ins, input Stall, input Stall_pm);
    modport slave  (input ins, output Stall, output Stall_pm);
`endif
endinterface

// File: rtl/stall_oneshot_counter.sv
// stall_oneshot_counter: inserts N stall cycles per occurrence of an opcode.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   hit   : the target opcode is present this cycle
//   stall : combinational stall request (not gated by reset here)
// While hit is held, the pattern is N stall cycles then one release cycle,
// repeating. Any cycle without hit restarts the count.
module stall_oneshot_counter #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    output logic stall
);
    localparam logic [1:0] LIMIT = 2'(N);

    logic [1:0] cnt;

    assign stall = hit && (cnt < LIMIT);

    // Count up through the stall cycles; the release cycle and any
    // non-matching cycle return to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt + 2'd1;
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/stall_control_block.sv
// stall_control_block: hazard stall generator for the NTP pipeline.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : stall_control_block_if.slave
//           ins in; Stall (combinational), Stall_pm (Stall delayed one clk) out;
//           stall_count out when STALL_STATS_EN is defined (saturating
//           count of Stall cycles, cleared by reset).
// HLT stalls every cycle it is present; LD and JMP stall for a fixed
// number of cycles per occurrence. Operand bits are ignored.
module stall_control_block
    import ntp_isa_pkg::*;
#(
    parameter int INS_W            = 24,
    parameter int LD_STALL_CYCLES  = 1,
    parameter int JMP_STALL_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    stall_control_block_if.slave bus
);
    logic [OPC_W-1:0] op;
    logic             hlt;
    logic             ld_stall;
    logic             jmp_stall;
    logic             unused_operand;

    assign op             = bus.ins[INS_W-1 -: OPC_W];
    assign unused_operand = ^bus.ins[INS_W-OPC_W-1:0];
    assign hlt            = (op == OPC_HLT);

    stall_oneshot_counter #(.N(LD_STALL_CYCLES)) u_ld_cnt (
        .clk   (clk),
        .reset (reset),
        .hit   (op == OPC_LD),
        .stall (ld_stall)
    );

    stall_oneshot_counter #(.N(JMP_STALL_CYCLES)) u_jmp_cnt (
        .clk   (clk),
        .reset (reset),
        .hit   (op == OPC_JMP),
        .stall (jmp_stall)
    );

    assign bus.Stall = ~reset & (hlt | ld_stall | jmp_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Stall_pm <= 1'b0;
        end else begin
            bus.Stall_pm <= bus.Stall;
        end
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stall_count <= '0;
        end else if (bus.Stall && (bus.stall_count != '1)) begin
            bus.stall_count <= bus.stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stall_control_block.sv
module tb_stall_control_block;
    localparam logic [4:0] HLT = 5'b10001;
    localparam logic [4:0] LD  = 5'b10100;
    localparam logic [4:0] JMP = 5'b11110;

    // Instance 0 uses defaults; instance 1 uses other stall lengths.
    localparam int LD0 = 1, JMP0 = 2;
    localparam int LD1 = 3, JMP1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    stall_control_block_if #(.INS_W(24)) bus0 ();
    stall_control_block_if #(.INS_W(24)) bus1 ();

    stall_control_block u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    stall_control_block #(
        .INS_W            (24),
        .LD_STALL_CYCLES  (LD1),
        .JMP_STALL_CYCLES (JMP1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic        s0;
        logic        p0;
        logic        s1;
        logic        p1;
        logic [15:0] c0;
        logic [15:0] c1;
        int          id;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc_id = 0;

    // Reference model state: length of the current run of identical opcodes.
    bit         prev_valid = 1'b0;
    logic [4:0] prev_op    = '0;
    int         run_pos    = 0;
    bit         prev_stall0 = 1'b0, prev_stall1 = 1'b0;
    int         acc0 = 0, acc1 = 0;

    // At position p inside a held run, the first n of every n+1 cycles stall.
    function automatic bit model_stall(input logic [4:0] op, input int p,
                                       input int nld, input int njmp);
        if (op == HLT) return 1'b1;
        if (op == LD)  return (p % (nld + 1)) < nld;
        if (op == JMP) return (p % (njmp + 1)) < njmp;
        return 1'b0;
    endfunction

    function automatic int sat_add(input int a, input bit s);
        int r;
        r = a + int'(s);
        return (r > 65535) ? 65535 : r;
    endfunction

    task automatic chk(input string name, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, id, act, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [23:0] w);
        exp_t e;
        logic [4:0] op;
        bit s0, s1;
        @(posedge clk);
        #1;
        reset    = r;
        bus0.ins = w;
        bus1.ins = w;
        op = w[23:19];
        if (r) begin
            s0 = 1'b0;
            s1 = 1'b0;
            prev_valid = 1'b0;
        end else begin
            run_pos = (prev_valid && op == prev_op) ? run_pos + 1 : 0;
            s0 = model_stall(op, run_pos, LD0, JMP0);
            s1 = model_stall(op, run_pos, LD1, JMP1);
            prev_valid = 1'b1;
            prev_op    = op;
        end
        e.s0 = s0;
        e.s1 = s1;
        e.p0 = prev_stall0;
        e.p1 = prev_stall1;
        e.c0 = 16'(acc0);
        e.c1 = 16'(acc1);
        e.id = cyc_id++;
        sb.push_back(e);
        prev_stall0 = s0;
        prev_stall1 = s1;
        acc0 = r ? 0 : sat_add(acc0, s0);
        acc1 = r ? 0 : sat_add(acc1, s1);
    endtask

    task automatic hold(input bit r, input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) drive(r, w);
    endtask

    // Monitor: every cycle is an output cycle; compare away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall0",    e.id, 16'(bus0.Stall),    16'(e.s0));
                chk("stall_pm0", e.id, 16'(bus0.Stall_pm), 16'(e.p0));
                chk("stall1",    e.id, 16'(bus1.Stall),    16'(e.s1));
                chk("stall_pm1", e.id, 16'(bus1.Stall_pm), 16'(e.p1));
`ifdef STALL_STATS_EN
                chk("count0",    e.id, bus0.stall_count,   e.c0);
                chk("count1",    e.id, bus1.stall_count,   e.c1);
`endif
            end
        end
    end

    initial begin
        logic [23:0] w;
        logic [4:0]  op;
        int          sel;
        bus0.ins = 24'hA00000;
        bus1.ins = 24'hA00000;
        repeat (2) @(posedge clk);

        // Directed scenarios
        hold(1'b1, 24'hA00000, 2);
        hold(1'b0, 24'hA00000, 2);
        hold(1'b0, 24'h000000, 3);
        hold(1'b0, 24'hA00000, 4);
        hold(1'b0, 24'h000000, 1);
        hold(1'b0, 24'hF00000, 6);
        hold(1'b0, 24'h880000, 5);
        hold(1'b0, 24'h000000, 2);
        hold(1'b0, 24'hF00000, 1);
        hold(1'b1, 24'hF00000, 1);
        hold(1'b0, 24'hF00000, 3);
        // Opcode switches mid-sequence, operand bits varying
        hold(1'b0, 24'hF12345, 1);
        hold(1'b0, 24'hA7FFFF, 2);
        hold(1'b0, 24'hF00001, 4);
        hold(1'b0, 24'h8FFFFF, 2);
        hold(1'b0, 24'hA00000, 5);

        // Randomized stimulus
        op = LD;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) >= 6) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: op = HLT;
                    1: op = LD;
                    2: op = JMP;
                    default: op = 5'($urandom);
                endcase
            end
            w = {op, 19'($urandom)};
            drive($urandom_range(0, 24) == 0, w);
        end

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
